key_pulse_gen: RTL and testbench
================================

// Module: key_pulse_gen
// PURPOSE
//   Upstream stage of the FPGAproj2301 counter. Turns a raw, bouncing push-button
//   input into a clean, fixed-width, single-shot enable pulse on `ena`, which drives
//   the counter's `ena` input. Exactly one pulse is produced per debounced press.
//   Also reports a busy level and a running press count for board LEDs and debug.
// PARAMETERS
//   DEBOUNCE_CYCLES  20   stable cycles required to accept a press or a release (>=2)
//   PULSE_LEN        3    width of the `ena` pulse in clk cycles (>=1)
//   KEY_ACTIVE_LOW   1    1: key_in==0 means pressed; 0: key_in==1 means pressed
//   CNT_W            8    width of press_cnt
// PORTS
//   clk        in   1      system clock, rising-edge
//   rst        in   1      synchronous reset, active-high
//   key_in     in   1      raw asynchronous button level
//   ena        out  1      registered one-shot enable pulse to downstream counter
//   busy       out  1      1 whenever FSM is not in IDLE
//   press_cnt  out  CNT_W  number of accepted presses, wraps modulo 2^CNT_W
// BEHAVIOUR
//   Reset (rst==1 at a clk edge): state=IDLE, deb counter=0, ena=0, busy=0, press_cnt=0,
//     both synchroniser flops load the RELEASED level. Reset mid-pulse: ena is 0 after that edge.
//   Sync: 2-flop synchroniser, normalised to key_s (1 = pressed); only key_s drives the FSM.
//   All outputs registered; ena and busy update on the same edge as the state register.
//   FSM:
//     IDLE        key_s==1 -> DEB_PRESS, dcnt<=0.
//     DEB_PRESS   key_s==0 -> IDLE (bounce rejected, no pulse).
//                 key_s==1 & dcnt==DEBOUNCE_CYCLES-1 -> PULSE, pcnt<=0, press_cnt++.
//                 else dcnt++.
//     PULSE       ena=1. pcnt++ each cycle; pcnt==PULSE_LEN-1 -> HELD. key_s ignored:
//                 a release/bounce here never shortens or repeats the pulse.
//     HELD        key_s==0 -> DEB_RELEASE, dcnt<=0. Holding the key never re-triggers.
//     DEB_RELEASE key_s==1 -> HELD (release bounce rejected).
//                 key_s==0 & dcnt==DEBOUNCE_CYCLES-1 -> IDLE. else dcnt++.
//   ena==1 iff state==PULSE; busy==1 iff state!=IDLE.
//   Latency: key_in first sampled pressed at edge 1, held stable -> ena high after edge
//     DEBOUNCE_CYCLES+3, low after edge DEBOUNCE_CYCLES+3+PULSE_LEN.
//   press_cnt: increments on the IDLE/DEB_PRESS->PULSE transition only; all-ones wraps to 0.
//   dcnt width = clog2(DEBOUNCE_CYCLES); pcnt width = clog2(PULSE_LEN)+1; no overflow reachable.
//   Unreachable state encodings recover to IDLE with ena=0 on the next edge.
// TESTING (DEBOUNCE_CYCLES=4, PULSE_LEN=3, KEY_ACTIVE_LOW=1, clk period 10)
//   1 Reset: rst=1 two edges, key_in=1 -> ena=0, busy=0, press_cnt=0.
//   2 Clean press: key_in 1->0 sampled at edge 1, held 40 cycles -> ena=1 after edges 7..9,
//     0 after edge 10; exactly one pulse; press_cnt=1; busy stays 1 until release debounced.
//   3 Press bounce: key_in low 2 cycles, high 1, low 2, high -> no ena pulse, press_cnt=0,
//     FSM back in IDLE (busy=0) within 3 cycles of final high.
//   4 Release bounce: after scenario 2, key_in toggles 0/1 every cycle for 6 cycles then
//     stays 1 -> no second pulse; busy=0 after 4 stable-released cycles (+sync delay).
//   5 Repeated presses: 257 clean press/release cycles -> 257 pulses of width 3;
//     press_cnt wraps 255->0 and ends at 1.
//   6 Reset mid-pulse: assert rst on the edge after ena rises -> ena=0, press_cnt=0,
//     busy=0; with key still held, a fresh full debounce precedes the next pulse.

Source files
------------

// File: rtl/key_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : key_pulse_gen
// Description : Push-button conditioner for the counter. It synchronises and
//               debounces a raw key and emits one fixed-width enable pulse for
//               each accepted press. It also provides a busy level and a
//               wrapping press counter.
// Revision    : 1.0 - initial release
// ============================================================================
module key_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int PULSE_LEN       = 3,
  parameter int KEY_ACTIVE_LOW  = 1,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_in,
  output logic             ena,
  output logic             busy,
  output logic [CNT_W-1:0] press_cnt
);

  localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int PCNT_W = $clog2(PULSE_LEN) + 1;

  localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(PULSE_LEN - 1);

  // Raw key level that means "not pressed"; the synchroniser resets to it
  localparam logic RELEASED_LVL = (KEY_ACTIVE_LOW != 0);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_DEB_PRESS   = 3'd1,
    S_PULSE       = 3'd2,
    S_HELD        = 3'd3,
    S_DEB_RELEASE = 3'd4
  } state_t;

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  state_t            state_q, state_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0]  press_cnt_q, press_cnt_d;
  logic              ena_q, ena_d;
  logic              busy_q, busy_d;
  logic              key_s;

  // Normalise the synchronised key so that 1 always means pressed
  assign key_s = sync2_q ^ RELEASED_LVL;

  // Next-state logic: synchroniser shift, debounce/pulse FSM, and outputs
  // derived from the next state so they change on the same edge as the state
  always_comb begin
    sync1_d     = key_in;
    sync2_d     = sync1_q;
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    pcnt_d      = pcnt_q;
    press_cnt_d = press_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (key_s) begin
          state_d = S_DEB_PRESS;
          dcnt_d  = '0;
        end
      end
      S_DEB_PRESS: begin
        if (!key_s) begin
          state_d = S_IDLE;
        end else if (dcnt_q == DCNT_MAX) begin
          state_d     = S_PULSE;
          pcnt_d      = '0;
          press_cnt_d = press_cnt_q + CNT_W'(1);
        end else begin
          dcnt_d = dcnt_q + DCNT_W'(1);
        end
      end
      S_PULSE: begin
        // The key is deliberately ignored so the pulse width is always exact
        if (pcnt_q == PCNT_MAX) begin
          state_d = S_HELD;
        end else begin
          pcnt_d = pcnt_q + PCNT_W'(1);
        end
      end
      S_HELD: begin
        if (!key_s) begin
          state_d = S_DEB_RELEASE;
          dcnt_d  = '0;
        end
      end
      S_DEB_RELEASE: begin
        if (key_s) begin
          state_d = S_HELD;
        end else if (dcnt_q == DCNT_MAX) begin
          state_d = S_IDLE;
        end else begin
          dcnt_d = dcnt_q + DCNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ena_d  = (state_d == S_PULSE);
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= RELEASED_LVL;
      sync2_q     <= RELEASED_LVL;
      state_q     <= S_IDLE;
      dcnt_q      <= '0;
      pcnt_q      <= '0;
      press_cnt_q <= '0;
      ena_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      pcnt_q      <= pcnt_d;
      press_cnt_q <= press_cnt_d;
      ena_q       <= ena_d;
      busy_q      <= busy_d;
    end
  end

  assign ena       = ena_q;
  assign busy      = busy_q;
  assign press_cnt = press_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_key_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_pulse_gen
// Description : Scoreboard bench for key_pulse_gen. Stimulus pushes each
//               expected pulse (start cycle, width, press count). A monitor
//               measures every ena pulse and compares it with the queue head.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_pulse_gen;

  localparam int DEB  = 4;
  localparam int PLEN = 3;
  localparam int CW   = 8;
  // Edge count between driving key_in and the first cycle ena is high
  localparam int LAT  = DEB + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          key_in = 1'b1;
  wire           ena;
  wire           busy;
  wire  [CW-1:0] press_cnt;

  key_pulse_gen #(
    .DEBOUNCE_CYCLES(DEB),
    .PULSE_LEN      (PLEN),
    .KEY_ACTIVE_LOW (1),
    .CNT_W          (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_in   (key_in),
    .ena      (ena),
    .busy     (busy),
    .press_cnt(press_cnt)
  );

  always #5 clk = ~clk;

  // cyc equals n right after rising edge n has been taken
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int start;
    int width;
    int cnt;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Measure each ena pulse on the falling edge and compare with the scoreboard
  int   mon_start = 0;
  int   mon_width = 0;
  int   mon_cnt   = 0;
  logic mon_in    = 1'b0;
  exp_t mon_exp;
  always @(negedge clk) begin
    if (ena === 1'b1) begin
      if (!mon_in) begin
        mon_in    = 1'b1;
        mon_start = cyc;
        mon_width = 1;
        mon_cnt   = int'(press_cnt);
      end else begin
        mon_width++;
      end
    end else if (mon_in) begin
      mon_in = 1'b0;
      if (sbq.size() == 0) begin
        check("unexpected_pulse_start", mon_start, -1);
      end else begin
        mon_exp = sbq.pop_front();
        check("pulse_start", mon_start, mon_exp.start);
        check("pulse_width", mon_width, mon_exp.width);
        check("pulse_press_cnt", mon_cnt, mon_exp.cnt);
      end
    end
  end

  // One clean press held for hold cycles, then release and let it debounce
  task automatic press_release(input int hold, input int exp_cnt);
    exp_t e;
    key_in  = 1'b0;
    e.start = cyc + LAT;
    e.width = PLEN;
    e.cnt   = exp_cnt;
    sbq.push_back(e);
    tick(hold);
    key_in = 1'b1;
    tick(DEB + 4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got cycle %0d expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   k;
    exp_t e;

    // Reset with key released
    rst    = 1'b1;
    key_in = 1'b1;
    tick(2);
    check("reset_ena", int'(ena), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_press_cnt", int'(press_cnt), 0);
    rst = 1'b0;
    tick(2);

    // Press bounce: low 2, high 1, low 2, then high
    key_in = 1'b0;
    tick(2);
    key_in = 1'b1;
    tick(1);
    key_in = 1'b0;
    tick(2);
    key_in = 1'b1;
    tick(2);
    check("bounce_busy_still_set", int'(busy), 1);
    tick(1);
    check("bounce_busy_idle", int'(busy), 0);
    check("bounce_press_cnt", int'(press_cnt), 0);

    // Clean press held 40 cycles
    k       = cyc;
    key_in  = 1'b0;
    e.start = k + LAT;
    e.width = PLEN;
    e.cnt   = 1;
    sbq.push_back(e);
    tick(2);
    check("press_busy_before_sync", int'(busy), 0);
    tick(1);
    check("press_busy_debounce", int'(busy), 1);
    tick(3);
    check("press_ena_before", int'(ena), 0);
    tick(1);
    check("press_ena_rise", int'(ena), 1);
    check("press_cnt_one", int'(press_cnt), 1);
    tick(2);
    check("press_ena_last", int'(ena), 1);
    tick(1);
    check("press_ena_fall", int'(ena), 0);
    tick(30);
    check("press_busy_held", int'(busy), 1);

    // Release bounce: toggle for 6 cycles then stay released
    for (int i = 0; i < 6; i++) begin
      key_in = (i % 2 == 0) ? 1'b1 : 1'b0;
      tick(1);
    end
    key_in = 1'b1;
    tick(6);
    check("release_busy_still_set", int'(busy), 1);
    tick(1);
    check("release_busy_idle", int'(busy), 0);
    check("release_press_cnt", int'(press_cnt), 1);

    // 257 repeated presses from a fresh reset
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    check("repeat_reset_cnt", int'(press_cnt), 0);
    for (int i = 1; i <= 257; i++) begin
      press_release(12, i % 256);
    end
    check("repeat_final_cnt", int'(press_cnt), 1);
    check("repeat_final_busy", int'(busy), 0);

    // Reset on the edge after ena rises, key still held
    k       = cyc;
    key_in  = 1'b0;
    e.start = k + LAT;
    e.width = 1;
    e.cnt   = 2;
    sbq.push_back(e);
    tick(LAT);
    check("midrst_ena_rise", int'(ena), 1);
    rst = 1'b1;
    tick(1);
    check("midrst_ena", int'(ena), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_press_cnt", int'(press_cnt), 0);
    rst     = 1'b0;
    e.start = k + LAT + 1 + LAT;
    e.width = PLEN;
    e.cnt   = 1;
    sbq.push_back(e);
    tick(LAT - 1);
    check("midrst_no_early_pulse", int'(ena), 0);
    tick(1);
    check("midrst_repulse", int'(ena), 1);
    check("midrst_repulse_cnt", int'(press_cnt), 1);
    tick(8);
    key_in = 1'b1;
    tick(DEB + 6);

    check("scoreboard_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
